// File: rtl/cache_bus_pkg.sv
// rtl/cache_bus_pkg.sv - shared constants and responder state type for the cache line bus
//
// Purpose: constants of the cache-to-arbiter line protocol (rw flag encoding,
// tag width, beats per line, line size) and the responder state enum.
// Ports: none (package).
package cache_bus_pkg;

  localparam logic READ       = 1'b1;
  localparam logic WRITE      = 1'b0;
  localparam int   TAGWIDTH   = 13;
  localparam int   BEATS      = 8;
  localparam int   LINE_BYTES = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_FILL,
    ST_WR_COLLECT,
    ST_WR_FLUSH,
    ST_WR_DONE
  } resp_state_e;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one-line write-back data buffer (BEATS x WORDSIZE)
//
// Purpose: holds the data words of a write-back between collection and flush.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write word
//   raddr_i  read word index
//   rdata_o  read word (combinational)
module line_buffer #(
  parameter  int WORDSIZE = 64,
  parameter  int BEATS    = 8,
  localparam int IDXW     = $clog2(BEATS)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [IDXW-1:0]     waddr_i,
  input  logic [WORDSIZE-1:0] wdata_i,
  input  logic [IDXW-1:0]     raddr_i,
  output logic [WORDSIZE-1:0] rdata_o
);

  // Pure storage: contents are only meaningful once written, so no reset.
  logic [WORDSIZE-1:0] words_q [BEATS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      words_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = words_q[raddr_i];

endmodule

// File: rtl/line_fill_responder.sv
// rtl/line_fill_responder.sv - cache line fill / write-back responder on a word memory port
//
// Purpose: accepts line-fill reads and line write-backs from an L1 cache and
// turns each into BEATS word accesses on the memory port; fill data returns
// to the cache as single-cycle beats, write-backs end with a writeack pulse.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   reqcyc/reqack/req/reqtag       cache request side (reqack one pulse per beat)
//   respcyc/respack/resp/resptag   fill beat return (respack never stalls)
//   writeack                       write-back committed pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_gnt   word access request
//   mem_rvalid/mem_rdata           in-order read data return
module line_fill_responder #(
  parameter int WORDSIZE = 64,
  parameter int TAGWIDTH = cache_bus_pkg::TAGWIDTH,
  parameter int BEATS    = cache_bus_pkg::BEATS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reqcyc,
  output logic                reqack,
  input  logic [WORDSIZE-1:0] req,
  input  logic [TAGWIDTH-1:0] reqtag,
  output logic                respcyc,
  input  logic                respack,
  output logic [WORDSIZE-1:0] resp,
  output logic [TAGWIDTH-1:0] resptag,
  output logic                writeack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [WORDSIZE-1:0] mem_rdata
);
  import cache_bus_pkg::*;

  localparam int LINEW = $clog2(LINE_BYTES);
  localparam int IDXW  = $clog2(BEATS);
  localparam int OFSW  = LINEW - IDXW;
  localparam int CNTW  = IDXW + 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(BEATS - 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(BEATS);

  resp_state_e state_q, state_d;

  // Only the line-aligned part of the address is kept; word offsets come
  // from the issue counter, so an access can never carry out of the line.
  logic [WORDSIZE-LINEW-1:0] base_q, base_d;
  logic [TAGWIDTH-1:0]       tag_q, tag_d;
  logic [CNTW-1:0]           icnt_q, icnt_d;
  logic [CNTW-1:0]           rcnt_q, rcnt_d;
  logic [CNTW-1:0]           wcnt_q, wcnt_d;
  logic                      reqack_q, reqack_d;
  logic                      respcyc_q, respcyc_d;
  logic [WORDSIZE-1:0]       resp_q, resp_d;
  logic [TAGWIDTH-1:0]       resptag_q, resptag_d;

  logic                      accept;
  logic                      grant;
  logic                      buf_we;
  logic [WORDSIZE-1:0]       buf_rdata;

  logic unused_respack;
  assign unused_respack = respack;

  // A beat is sampled only while reqack is low, so each beat costs at least
  // two cycles and reqack can never be high twice in a row.
  assign accept = reqcyc && !reqack_q;
  assign grant  = mem_req && mem_gnt;

  line_buffer #(
    .WORDSIZE (WORDSIZE),
    .BEATS    (BEATS)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wcnt_q[IDXW-1:0]),
    .wdata_i (req),
    .raddr_i (icnt_q[IDXW-1:0]),
    .rdata_o (buf_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (reqtag[TAGWIDTH-1])
            READ:  state_d = ST_RD_FILL;
            WRITE: state_d = ST_WR_COLLECT;
          endcase
        end
      end
      ST_RD_FILL: begin
        if (mem_rvalid && rcnt_q == LAST) state_d = ST_IDLE;
      end
      ST_WR_COLLECT: begin
        if (accept && wcnt_q == LAST) state_d = ST_WR_FLUSH;
      end
      ST_WR_FLUSH: begin
        if (grant && icnt_q == LAST) state_d = ST_WR_DONE;
      end
      ST_WR_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: memory port and writeack follow the state directly
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    writeack  = 1'b0;
    unique case (state_q)
      ST_RD_FILL: begin
        mem_req = (icnt_q < FULL);
      end
      ST_WR_FLUSH: begin
        mem_req   = (icnt_q < FULL);
        mem_we    = mem_req;
        mem_wdata = mem_req ? buf_rdata : '0;
      end
      ST_WR_DONE: writeack = 1'b1;
      default: ;
    endcase
    if (mem_req) begin
      mem_addr = {base_q, icnt_q[IDXW-1:0], {OFSW{1'b0}}};
    end
  end

  // Datapath next-state: latches, counters, registered handshake outputs
  always_comb begin
    base_d    = base_q;
    tag_d     = tag_q;
    icnt_d    = icnt_q;
    rcnt_d    = rcnt_q;
    wcnt_d    = wcnt_q;
    reqack_d  = 1'b0;
    respcyc_d = 1'b0;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    buf_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          base_d   = req[WORDSIZE-1:LINEW];
          tag_d    = reqtag;
          reqack_d = 1'b1;
          icnt_d   = '0;
          rcnt_d   = '0;
          wcnt_d   = '0;
        end
      end
      ST_RD_FILL: begin
        if (grant) icnt_d = icnt_q + CNTW'(1);
        if (mem_rvalid) begin
          respcyc_d = 1'b1;
          resp_d    = mem_rdata;
          resptag_d = tag_q;
          rcnt_d    = rcnt_q + CNTW'(1);
        end
      end
      ST_WR_COLLECT: begin
        if (accept) begin
          buf_we   = 1'b1;
          reqack_d = 1'b1;
          wcnt_d   = wcnt_q + CNTW'(1);
        end
      end
      ST_WR_FLUSH: begin
        if (grant) icnt_d = icnt_q + CNTW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      tag_q     <= '0;
      icnt_q    <= '0;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      base_q    <= base_d;
      tag_q     <= tag_d;
      icnt_q    <= icnt_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  assign reqack  = reqack_q;
  assign respcyc = respcyc_q;
  assign resp    = resp_q;
  assign resptag = resptag_q;

endmodule

// File: doc/line_fill_responder.md
# line_fill_responder

Responder end of the cache-to-arbiter line protocol: accepts 64-byte line-fill reads and line write-backs from an L1 cache, converts each into eight word accesses on a word-wide memory port, and returns fill data as eight single-cycle beats. Sits between a direct-mapped L1 cache and the main-memory port, one instance per cache.

## Interface
Parameters:
- WORDSIZE, 64, data/address width.
- TAGWIDTH, 13, request tag width; bit TAGWIDTH-1 is the read/write flag.
- BEATS, 8, words per line (line = BEATS*WORDSIZE/8 bytes = 64).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- reqcyc  in  1  cache request valid.
- reqack  out  1  one-cycle acceptance pulse per request beat.
- req  in  WORDSIZE  line address (first beat), write data (subsequent write beats).
- reqtag  in  TAGWIDTH  {rw, id[11:0]}; rw=READ(1) fill, WRITE(0) write-back.
- respcyc  out  1  fill beat valid, exactly one cycle per beat.
- respack  in  1  cache beat acknowledge; informational, never stalls.
- resp  out  WORDSIZE  fill beat data.
- resptag  out  TAGWIDTH  tag of the request being answered.
- writeack  out  1  one-cycle pulse: write-back committed to memory.
- mem_req  out  1  word access request.
- mem_we  out  1  1=write.
- mem_addr  out  WORDSIZE  word byte address.
- mem_wdata  out  WORDSIZE  write data.
- mem_gnt  in  1  access accepted this cycle when mem_req&mem_gnt.
- mem_rvalid  in  1  read data valid, in order.
- mem_rdata  in  WORDSIZE  read data.

## Operation
- States: IDLE, RD_FILL, WR_COLLECT, WR_FLUSH, WR_DONE.
- IDLE: at edge with reqcyc=1, reqack=0: latch base = req & ~63, tag = reqtag; assert reqack next cycle; go RD_FILL if reqtag[TAGWIDTH-1]=READ else WR_COLLECT.
- RD_FILL: issue mem reads base+8*i, i=0..7, mem_we=0; issue counter advances on mem_req&mem_gnt; stop requesting after 8 grants. Each mem_rvalid forwards next cycle as respcyc=1, resp=mem_rdata, resptag=tag; return counter counts beats. After 8th beat -> IDLE. No reordering; gaps between beats permitted.
- WR_COLLECT: per beat, sample req when reqcyc=1 and reqack=0; store in line buffer[wcnt]; pulse reqack. After 8 data beats -> WR_FLUSH.
- WR_FLUSH: issue mem writes base+8*i with buffer[i], mem_we=1, advance on grant; after 8th grant -> WR_DONE.
- WR_DONE: writeack=1 one cycle, -> IDLE.
- mem_rvalid outside RD_FILL ignored. respack ignored for flow control.
- Counters 4-bit (0..8); addresses computed base + {i,3'b000}, low 6 bits of base forced 0, no carry out of line.

## Timing
- Reset values: reqack, respcyc, writeack, mem_req, mem_we = 0; resp, resptag, mem_addr, mem_wdata = 0; state IDLE, counters 0. Reset mid-operation abandons transfer; no writeack, no further beats.
- reqack is registered: request sampled at edge N -> reqack high cycle N+1 -> next sample no earlier than edge N+2. Minimum 2 cycles per request beat; reqack never high two consecutive cycles.
- First mem_req asserted cycle after acceptance. Fill beat latency: mem_rvalid at edge M -> respcyc high cycle M+1.
- Write-back: writeack one cycle after 8th write grant.
- mem_req held with stable addr/data until granted.

## Structure
- Package cache_bus_pkg: READ=1'b1, WRITE=1'b0 constants, TAGWIDTH, BEATS, LINE_BYTES=64, responder state enum.
- One sub-module: line_buffer (8xWORDSIZE register file, one write port indexed by wcnt, one read port indexed by issue counter).

## Test plan
- Fill, mem_gnt always 1, rvalid 2 cycles after grant, req=0x1048 READ id=5 -> mem_addr 0x1040..0x1078, 8 respcyc beats with resptag {1,5}, then IDLE.
- Fill with mem_gnt toggling and rvalid gaps -> exactly 8 single-cycle beats in address order, no beat lost or duplicated.
- Write-back base 0x2000, data 0xA0..0xA7 -> reqack 9 pulses never adjacent; mem writes 0x2000..0x2038 with 0xA0..0xA7; writeack one pulse.
- Back-to-back write-back then fill to same line -> fill returns 0xA0..0xA7 from memory model.
- Reset asserted after 3rd fill beat -> all outputs 0 next cycle, stray rvalid ignored, new request served correctly.
